age_issue_queue: RTL and testbench
==================================

AGE_ISSUE_QUEUE -- requirements
Module: age_issue_queue

Interface
REQ-001 SHALL have parameter QUEUE_LEN, default 8: entry capacity; constraint 2..32.
REQ-002 SHALL have parameter WRITE_NUM, default 2: dispatch lanes; constraint WRITE_NUM <= QUEUE_LEN.
REQ-003 SHALL have parameter READ_NUM, default 2: issue ports; constraint READ_NUM <= QUEUE_LEN.
REQ-004 SHALL have parameter WAKE_NUM, default 4: wakeup/broadcast ports.
REQ-005 SHALL have parameters DATA_WIDTH=32, TAG_WIDTH=6, PAYLOAD_WIDTH=32: operand, physical tag and opaque payload widths.
REQ-006 SHALL provide ports: clk in 1, clock; resetn in 1, asynchronous active-low reset.
REQ-007 SHALL provide ports: flush in 1, synchronous queue clear.
REQ-008 SHALL provide ports, per write lane: in_valid in WRITE_NUM; in_payload in WRITE_NUM*PAYLOAD_WIDTH.
REQ-009 SHALL provide ports, per write lane: in_src1_tag/in_src2_tag in WRITE_NUM*TAG_WIDTH; in_src1_rdy/in_src2_rdy in WRITE_NUM; in_src1_data/in_src2_data in WRITE_NUM*DATA_WIDTH.
REQ-010 SHALL provide ports: in_ready out 1, all dispatch lanes may be accepted this cycle.
REQ-011 SHALL provide ports: wake_valid in WAKE_NUM; wake_tag in WAKE_NUM*TAG_WIDTH; wake_data in WAKE_NUM*DATA_WIDTH.
REQ-012 SHALL provide ports: out_valid out READ_NUM; out_ready in READ_NUM; out_payload out READ_NUM*PAYLOAD_WIDTH; out_src1_data/out_src2_data out READ_NUM*DATA_WIDTH.
REQ-013 SHALL provide ports: count out $clog2(QUEUE_LEN+1), occupied entries.

Function
REQ-014 SHALL hold entries in age order: slot 0 oldest, slots 0..count-1 valid, no holes.
REQ-015 SHALL drive in_ready = (count <= QUEUE_LEN-WRITE_NUM) && !flush, from registered count only; no path from out_ready.
REQ-016 SHALL accept lane i iff in_valid[i] && in_ready; accepted lanes append after survivors, lower lane index older, invalid lanes skipped with no hole.
REQ-017 SHALL, for stored operands with rdy=0 and a matching valid wake port, set rdy=1 and capture wake_data at the clock edge; the lowest-indexed matching port wins.
REQ-018 SHALL apply REQ-017 to operands of accepted writes in the same cycle (wake bypass); an operand already rdy keeps its data.
REQ-019 SHALL select, combinationally from registered state, the READ_NUM oldest entries with both operands rdy; port k presents the k-th oldest.
REQ-020 SHALL drive out_valid[k]=0 when fewer than k+1 ready entries exist; unused ports' data is don't-care.
REQ-021 SHALL treat a wake in cycle N as eligible for issue no earlier than cycle N+1; zero-cycle write-to-issue is not supported.
REQ-022 SHALL issue port k iff out_valid[k] && out_ready[k]; a stalled port's entry stays queued and later ports still fire independently.
REQ-023 SHALL remove issued entries at the clock edge, compact survivors preserving order, then append writes: count_next = count - issued + accepted.
REQ-024 SHALL never overflow (guaranteed by REQ-015) nor underflow; simultaneous issue and write in one cycle SHALL be legal.
REQ-025 SHALL, when flush=1, force out_valid=0, in_ready=0, discard writes and wakes, and give count=0 next cycle.

Reset
REQ-026 SHALL, while resetn=0 (asynchronous), clear all entries, count=0, out_valid=0; in_ready=1 after release when flush=0.
REQ-027 SHALL, on reset mid-operation, lose all queued entries, with no output until new dispatch.

Verification
REQ-028 Oldest-first check: dispatch A(ready), B(ready), C(ready) over two cycles, out_ready=2'b11 -> port0=A, port1=B; next cycle port0=C; count 3->1->0.
REQ-029 Wake and bypass check: entry X with src1 tag 5 unready; wake_valid[2]=1 tag 5 data 0xDEAD in the same cycle lane0 writes Y with src2 tag 5 -> both capture 0xDEAD, both issue next cycle.
REQ-030 Full check, QUEUE_LEN=8, WRITE_NUM=2: fill to 7 unready -> in_ready=0; in_valid held, no entry accepted, count stays 7; wake one entry, issue -> count 6 -> in_ready=1.
REQ-031 Port stall check: three ready entries P,Q,R with out_ready=2'b10 -> port0=P stalls, port1=Q issues; next cycle port0=P, port1=R, order preserved.
REQ-032 Flush/reset check: flush with 5 entries and write pending -> out_valid=0, count=0 next cycle; resetn low mid-cycle -> outputs cleared immediately.
REQ-033 Duplicate-tag check: wake ports 0 and 3 same tag, data 0x11/0x22 -> operand captures 0x11.

Source files
------------

// File: rtl/age_issue_queue_if.sv
// Dispatch, wakeup, issue and status signals of the age-ordered issue queue.
// The slave modport is the queue side; the master modport is the dispatch/issue side.
interface age_issue_queue_if #(
  parameter int unsigned QUEUE_LEN     = 8,
  parameter int unsigned WRITE_NUM     = 2,
  parameter int unsigned READ_NUM      = 2,
  parameter int unsigned WAKE_NUM      = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TAG_WIDTH     = 6,
  parameter int unsigned PAYLOAD_WIDTH = 32
) ();

  localparam int unsigned CntW = $clog2(QUEUE_LEN + 1);

  logic                               flush;
  logic [WRITE_NUM-1:0]               in_valid;
  logic [WRITE_NUM*PAYLOAD_WIDTH-1:0] in_payload;
  logic [WRITE_NUM*TAG_WIDTH-1:0]     in_src1_tag;
  logic [WRITE_NUM*TAG_WIDTH-1:0]     in_src2_tag;
  logic [WRITE_NUM-1:0]               in_src1_rdy;
  logic [WRITE_NUM-1:0]               in_src2_rdy;
  logic [WRITE_NUM*DATA_WIDTH-1:0]    in_src1_data;
  logic [WRITE_NUM*DATA_WIDTH-1:0]    in_src2_data;
  logic                               in_ready;
  logic [WAKE_NUM-1:0]                wake_valid;
  logic [WAKE_NUM*TAG_WIDTH-1:0]      wake_tag;
  logic [WAKE_NUM*DATA_WIDTH-1:0]     wake_data;
  logic [READ_NUM-1:0]                out_valid;
  logic [READ_NUM-1:0]                out_ready;
  logic [READ_NUM*PAYLOAD_WIDTH-1:0]  out_payload;
  logic [READ_NUM*DATA_WIDTH-1:0]     out_src1_data;
  logic [READ_NUM*DATA_WIDTH-1:0]     out_src2_data;
  logic [CntW-1:0]                    count;

  modport master (
    output flush, in_valid, in_payload, in_src1_tag, in_src2_tag, in_src1_rdy, in_src2_rdy,
    output in_src1_data, in_src2_data, wake_valid, wake_tag, wake_data, out_ready,
    input  in_ready, out_valid, out_payload, out_src1_data, out_src2_data, count
  );

  modport slave (
    input  flush, in_valid, in_payload, in_src1_tag, in_src2_tag, in_src1_rdy, in_src2_rdy,
    input  in_src1_data, in_src2_data, wake_valid, wake_tag, wake_data, out_ready,
    output in_ready, out_valid, out_payload, out_src1_data, out_src2_data, count
  );

endinterface

// File: rtl/age_issue_queue.sv
// Age-ordered issue queue: compacting entry array (slot 0 oldest) with operand wakeup,
// same-cycle wake bypass on dispatch, and oldest-ready-first selection over READ_NUM ports.
module age_issue_queue #(
  parameter int unsigned QUEUE_LEN     = 8,
  parameter int unsigned WRITE_NUM     = 2,
  parameter int unsigned READ_NUM      = 2,
  parameter int unsigned WAKE_NUM      = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TAG_WIDTH     = 6,
  parameter int unsigned PAYLOAD_WIDTH = 32
) (
  input logic              clk,
  input logic              resetn,
  age_issue_queue_if.slave bus
);

  localparam int unsigned CntW = $clog2(QUEUE_LEN + 1);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic                  rdy;
    logic [DATA_WIDTH-1:0] data;
  } op_t;

  typedef struct packed {
    logic [PAYLOAD_WIDTH-1:0] payload;
    op_t                      src1;
    op_t                      src2;
  } entry_t;

  entry_t          r_q [QUEUE_LEN];
  logic [CntW-1:0] r_count;

  entry_t                            w_q_d      [QUEUE_LEN];
  entry_t                            w_woken    [QUEUE_LEN];
  entry_t                            w_in_woken [WRITE_NUM];
  logic [CntW-1:0]                   w_rank     [QUEUE_LEN];
  logic [CntW-1:0]                   w_pos      [QUEUE_LEN];
  logic [CntW-1:0]                   w_lpos     [WRITE_NUM];
  logic [QUEUE_LEN-1:0]              w_slot_vld;
  logic [QUEUE_LEN-1:0]              w_slot_rdy;
  logic [QUEUE_LEN-1:0]              w_issue;
  logic [WRITE_NUM-1:0]              w_acc;
  logic                              w_in_ready;
  logic [CntW-1:0]                   w_count_d;
  logic [READ_NUM-1:0]               w_out_valid;
  logic [READ_NUM*PAYLOAD_WIDTH-1:0] w_out_payload;
  logic [READ_NUM*DATA_WIDTH-1:0]    w_out_d1;
  logic [READ_NUM*DATA_WIDTH-1:0]    w_out_d2;

  function automatic op_t wake_op(input op_t                           op,
                                  input logic [WAKE_NUM-1:0]            vld,
                                  input logic [WAKE_NUM*TAG_WIDTH-1:0]  tags,
                                  input logic [WAKE_NUM*DATA_WIDTH-1:0] data);
    op_t res;
    res = op;
    // Descending scan: the lowest-indexed matching port is applied last and wins.
    for (int p = int'(WAKE_NUM) - 1; p >= 0; p--) begin
      if (!op.rdy && vld[p] && (tags[p*TAG_WIDTH +: TAG_WIDTH] == op.tag)) begin
        res.rdy  = 1'b1;
        res.data = data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return res;
  endfunction

  assign w_in_ready = (r_count <= CntW'(QUEUE_LEN - WRITE_NUM)) && !bus.flush;
  assign w_acc      = bus.in_valid & {WRITE_NUM{w_in_ready}};

  always_comb begin
    op_t o1;
    op_t o2;
    for (int unsigned i = 0; i < QUEUE_LEN; i++) begin
      w_woken[i].payload = r_q[i].payload;
      w_woken[i].src1    = wake_op(r_q[i].src1, bus.wake_valid, bus.wake_tag, bus.wake_data);
      w_woken[i].src2    = wake_op(r_q[i].src2, bus.wake_valid, bus.wake_tag, bus.wake_data);
    end
    for (int unsigned l = 0; l < WRITE_NUM; l++) begin
      o1.tag  = bus.in_src1_tag[l*TAG_WIDTH +: TAG_WIDTH];
      o1.rdy  = bus.in_src1_rdy[l];
      o1.data = bus.in_src1_data[l*DATA_WIDTH +: DATA_WIDTH];
      o2.tag  = bus.in_src2_tag[l*TAG_WIDTH +: TAG_WIDTH];
      o2.rdy  = bus.in_src2_rdy[l];
      o2.data = bus.in_src2_data[l*DATA_WIDTH +: DATA_WIDTH];
      w_in_woken[l].payload = bus.in_payload[l*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      w_in_woken[l].src1    = wake_op(o1, bus.wake_valid, bus.wake_tag, bus.wake_data);
      w_in_woken[l].src2    = wake_op(o2, bus.wake_valid, bus.wake_tag, bus.wake_data);
    end
  end

  // Rank each ready slot among older ready slots; rank k drives issue port k.
  always_comb begin
    logic [CntW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < QUEUE_LEN; i++) begin
      w_slot_vld[i] = CntW'(i) < r_count;
      w_slot_rdy[i] = w_slot_vld[i] && r_q[i].src1.rdy && r_q[i].src2.rdy;
      w_rank[i]     = n;
      if (w_slot_rdy[i]) n = n + 1'b1;
    end
  end

  always_comb begin
    w_out_valid   = '0;
    w_out_payload = '0;
    w_out_d1      = '0;
    w_out_d2      = '0;
    w_issue       = '0;
    for (int unsigned k = 0; k < READ_NUM; k++) begin
      for (int unsigned i = 0; i < QUEUE_LEN; i++) begin
        if (w_slot_rdy[i] && (w_rank[i] == CntW'(k))) begin
          w_out_valid[k]                            = !bus.flush;
          w_out_payload[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = r_q[i].payload;
          w_out_d1[k*DATA_WIDTH +: DATA_WIDTH]      = r_q[i].src1.data;
          w_out_d2[k*DATA_WIDTH +: DATA_WIDTH]      = r_q[i].src2.data;
          w_issue[i]                                = !bus.flush && bus.out_ready[k];
        end
      end
    end
  end

  // Destination slot of each survivor, then of each accepted lane appended behind them.
  always_comb begin
    logic [CntW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < QUEUE_LEN; i++) begin
      w_pos[i] = n;
      if (w_slot_vld[i] && !w_issue[i]) n = n + 1'b1;
    end
    for (int unsigned l = 0; l < WRITE_NUM; l++) begin
      w_lpos[l] = n;
      if (w_acc[l]) n = n + 1'b1;
    end
    w_count_d = bus.flush ? '0 : n;
  end

  always_comb begin
    for (int unsigned d = 0; d < QUEUE_LEN; d++) begin
      w_q_d[d] = r_q[d];
      for (int unsigned i = 0; i < QUEUE_LEN; i++) begin
        if (w_slot_vld[i] && !w_issue[i] && (w_pos[i] == CntW'(d))) w_q_d[d] = w_woken[i];
      end
      for (int unsigned l = 0; l < WRITE_NUM; l++) begin
        if (w_acc[l] && (w_lpos[l] == CntW'(d))) w_q_d[d] = w_in_woken[l];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
      r_q     <= '{default: '0};
    end else begin
      r_count <= w_count_d;
      r_q     <= w_q_d;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_payload   = w_out_payload;
  assign bus.out_src1_data = w_out_d1;
  assign bus.out_src2_data = w_out_d2;
  assign bus.count         = r_count;

endmodule

// File: tb/tb_age_issue_queue.sv
// Directed bench for age_issue_queue: ordering, wakeup/bypass, full, stall, flush, reset.
module tb_age_issue_queue;

  localparam int unsigned QL = 8;
  localparam int unsigned WN = 2;
  localparam int unsigned RN = 2;
  localparam int unsigned KN = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 6;
  localparam int unsigned PW = 32;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  age_issue_queue_if #(
    .QUEUE_LEN(QL), .WRITE_NUM(WN), .READ_NUM(RN), .WAKE_NUM(KN),
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)
  ) bus ();

  age_issue_queue #(
    .QUEUE_LEN(QL), .WRITE_NUM(WN), .READ_NUM(RN), .WAKE_NUM(KN),
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush        = 1'b0;
    bus.in_valid     = '0;
    bus.in_payload   = '0;
    bus.in_src1_tag  = '0;
    bus.in_src2_tag  = '0;
    bus.in_src1_rdy  = '0;
    bus.in_src2_rdy  = '0;
    bus.in_src1_data = '0;
    bus.in_src2_data = '0;
    bus.wake_valid   = '0;
    bus.wake_tag     = '0;
    bus.wake_data    = '0;
    bus.out_ready    = '0;
  endtask

  task automatic lane(input int unsigned l, input logic [31:0] p,
                      input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                      input logic [5:0] t2, input logic r2, input logic [31:0] d2);
    bus.in_valid[l]              = 1'b1;
    bus.in_payload[l*PW +: PW]   = p;
    bus.in_src1_tag[l*TW +: TW]  = t1;
    bus.in_src1_rdy[l]           = r1;
    bus.in_src1_data[l*DW +: DW] = d1;
    bus.in_src2_tag[l*TW +: TW]  = t2;
    bus.in_src2_rdy[l]           = r2;
    bus.in_src2_data[l*DW +: DW] = d2;
  endtask

  // Both operands ready; operand data derived from the payload.
  task automatic rlane(input int unsigned l, input logic [31:0] p);
    lane(l, p, 6'd0, 1'b1, p + 32'd1, 6'd0, 1'b1, p + 32'd2);
  endtask

  task automatic wake(input int unsigned k, input logic [5:0] t, input logic [31:0] d);
    bus.wake_valid[k]         = 1'b1;
    bus.wake_tag[k*TW +: TW]  = t;
    bus.wake_data[k*DW +: DW] = d;
  endtask

  task automatic flush_clear();
    idle();
    bus.flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    #12;
    checks++;
    if (bus.count !== 4'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", bus.count);
    end
    checks++;
    if (bus.out_valid !== 2'b00) begin
      errors++; $display("FAIL reset_out_valid got %b exp 00", bus.out_valid);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_oldest_first();
    idle(); rlane(0, 32'hA0); rlane(1, 32'hB0); tick();
    idle(); rlane(0, 32'hC0); tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd3) begin
      errors++; $display("FAIL oldest_count3 got %0d exp 3", bus.count);
    end
    checks++;
    if (bus.out_valid !== 2'b11) begin
      errors++; $display("FAIL oldest_valid got %b exp 11", bus.out_valid);
    end
    checks++;
    if (bus.out_payload !== {32'hB0, 32'hA0}) begin
      errors++; $display("FAIL oldest_ports got %h exp b0/a0", bus.out_payload);
    end
    checks++;
    if (bus.out_src1_data[31:0] !== 32'hA1 || bus.out_src2_data[63:32] !== 32'hB2) begin
      errors++;
      $display("FAIL oldest_data got %h %h exp a1 b2", bus.out_src1_data, bus.out_src2_data);
    end
    bus.out_ready = 2'b11; tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd1 || bus.out_valid !== 2'b01 || bus.out_payload[31:0] !== 32'hC0) begin
      errors++;
      $display("FAIL oldest_second got %0d %b %h exp 1 01 c0", bus.count, bus.out_valid,
               bus.out_payload[31:0]);
    end
    bus.out_ready = 2'b11; tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd0 || bus.out_valid !== 2'b00) begin
      errors++; $display("FAIL oldest_empty got %0d %b exp 0 00", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_wake_bypass();
    idle(); lane(0, 32'h58, 6'd5, 1'b0, 32'h0, 6'd0, 1'b1, 32'h222); tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd1 || bus.out_valid !== 2'b00) begin
      errors++; $display("FAIL wake_unready got %0d %b exp 1 00", bus.count, bus.out_valid);
    end
    lane(0, 32'h59, 6'd5, 1'b1, 32'h333, 6'd5, 1'b0, 32'h0);
    wake(2, 6'd5, 32'hDEAD);
    #1;
    checks++;
    if (bus.out_valid !== 2'b00) begin
      errors++; $display("FAIL wake_same_cycle got %b exp 00", bus.out_valid);
    end
    tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd2 || bus.out_valid !== 2'b11 ||
        bus.out_payload !== {32'h59, 32'h58}) begin
      errors++;
      $display("FAIL wake_issue got %0d %b %h exp 2 11 59/58", bus.count, bus.out_valid,
               bus.out_payload);
    end
    checks++;
    if (bus.out_src1_data !== {32'h333, 32'hDEAD} || bus.out_src2_data !== {32'hDEAD, 32'h222})
    begin
      errors++;
      $display("FAIL wake_data got %h %h exp 333/dead dead/222", bus.out_src1_data,
               bus.out_src2_data);
    end
    bus.out_ready = 2'b11; tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd0) begin
      errors++; $display("FAIL wake_drain got %0d exp 0", bus.count);
    end
  endtask

  task automatic test_dup_tag();
    idle(); lane(0, 32'hDD, 6'd7, 1'b0, 32'h0, 6'd0, 1'b1, 32'h5); tick();
    idle(); wake(0, 6'd7, 32'h11); wake(3, 6'd7, 32'h22); tick();
    idle(); #1;
    checks++;
    if (bus.out_valid !== 2'b01 || bus.out_src1_data[31:0] !== 32'h11) begin
      errors++;
      $display("FAIL dup_tag got %b %h exp 01 11", bus.out_valid, bus.out_src1_data[31:0]);
    end
    bus.out_ready = 2'b01; tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd0) begin
      errors++; $display("FAIL dup_drain got %0d exp 0", bus.count);
    end
  endtask

  task automatic test_full();
    for (int unsigned i = 0; i < 3; i++) begin
      idle();
      lane(0, 32'hE0 + 2 * i, 6'(10 + 2 * i), 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
      lane(1, 32'hE1 + 2 * i, 6'(11 + 2 * i), 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
      tick();
    end
    idle(); #1;
    checks++;
    if (bus.count !== 4'd6 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL full_six got %0d %b exp 6 1", bus.count, bus.in_ready);
    end
    lane(0, 32'hE6, 6'd16, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0); tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd7 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL full_seven got %0d %b exp 7 0", bus.count, bus.in_ready);
    end
    rlane(0, 32'hF0); rlane(1, 32'hF1); wake(1, 6'd13, 32'h1313); tick();
    bus.wake_valid = '0; #1;
    checks++;
    if (bus.count !== 4'd7 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL full_hold got %0d %b exp 7 0", bus.count, bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 2'b01 || bus.out_payload[31:0] !== 32'hE3 ||
        bus.out_src1_data[31:0] !== 32'h1313) begin
      errors++;
      $display("FAIL full_woken got %b %h %h exp 01 e3 1313", bus.out_valid,
               bus.out_payload[31:0], bus.out_src1_data[31:0]);
    end
    bus.out_ready = 2'b01; tick();
    bus.out_ready = 2'b00; #1;
    checks++;
    if (bus.count !== 4'd6 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL full_release got %0d %b exp 6 1", bus.count, bus.in_ready);
    end
    flush_clear();
  endtask

  task automatic test_port_stall();
    idle(); rlane(0, 32'hA1); rlane(1, 32'hA2); tick();
    idle(); rlane(0, 32'hA3); tick();
    idle(); bus.out_ready = 2'b10; #1;
    checks++;
    if (bus.count !== 4'd3 || bus.out_valid !== 2'b11 || bus.out_payload !== {32'hA2, 32'hA1})
    begin
      errors++;
      $display("FAIL stall_first got %0d %b %h exp 3 11 a2/a1", bus.count, bus.out_valid,
               bus.out_payload);
    end
    tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd2 || bus.out_valid !== 2'b11 || bus.out_payload !== {32'hA3, 32'hA1})
    begin
      errors++;
      $display("FAIL stall_second got %0d %b %h exp 2 11 a3/a1", bus.count, bus.out_valid,
               bus.out_payload);
    end
    bus.out_ready = 2'b11; tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd0) begin
      errors++; $display("FAIL stall_drain got %0d exp 0", bus.count);
    end
  endtask

  task automatic test_back_to_back();
    idle(); rlane(0, 32'hB1); rlane(1, 32'hB2); tick();
    // Issue the oldest while only lane 1 dispatches: new entry lands right behind B2.
    idle(); bus.out_ready = 2'b01; rlane(1, 32'hB3); tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd2 || bus.out_valid !== 2'b11 || bus.out_payload !== {32'hB3, 32'hB2})
    begin
      errors++;
      $display("FAIL b2b_first got %0d %b %h exp 2 11 b3/b2", bus.count, bus.out_valid,
               bus.out_payload);
    end
    bus.out_ready = 2'b11; rlane(0, 32'hB4); rlane(1, 32'hB5); tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd2 || bus.out_payload !== {32'hB5, 32'hB4}) begin
      errors++;
      $display("FAIL b2b_second got %0d %h exp 2 b5/b4", bus.count, bus.out_payload);
    end
    flush_clear();
  endtask

  task automatic test_flush();
    idle(); rlane(0, 32'hC1); rlane(1, 32'hC2); tick();
    idle(); rlane(0, 32'hC3); rlane(1, 32'hC4); tick();
    idle(); rlane(0, 32'hC5); tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd5) begin
      errors++; $display("FAIL flush_fill got %0d exp 5", bus.count);
    end
    bus.flush = 1'b1; bus.out_ready = 2'b11;
    rlane(0, 32'hC6); rlane(1, 32'hC7); wake(0, 6'd1, 32'h77);
    #1;
    checks++;
    if (bus.out_valid !== 2'b00 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_comb got %b %b exp 00 0", bus.out_valid, bus.in_ready);
    end
    tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd0 || bus.out_valid !== 2'b00 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_after got %0d %b %b exp 0 00 1", bus.count, bus.out_valid,
               bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    idle(); rlane(0, 32'hD1); rlane(1, 32'hD2); tick();
    idle(); #1;
    checks++;
    if (bus.count !== 4'd2 || bus.out_valid !== 2'b11) begin
      errors++; $display("FAIL areset_pre got %0d %b exp 2 11", bus.count, bus.out_valid);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.count !== 4'd0 || bus.out_valid !== 2'b00) begin
      errors++; $display("FAIL areset_now got %0d %b exp 0 00", bus.count, bus.out_valid);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick(); #1;
    checks++;
    if (bus.count !== 4'd0 || bus.out_valid !== 2'b00 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_after got %0d %b %b exp 0 00 1", bus.count, bus.out_valid,
               bus.in_ready);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_oldest_first();
    test_wake_bypass();
    test_dup_tag();
    test_full();
    test_port_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
